// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- hazard unit for a five-stage in-order pipeline.
// Provides operand forwarding selects, load-use stalls, taken-branch flushes,
// a post-reset pipeline flush sequence and a data-memory wait stall with a
// sticky timeout flag.
// Optional feature: define HAZARD_PERF_EN to build the stall/flush
// performance counters; without it stallCnt and flushCnt read as zero.
module hazard_ctrl #(
  parameter int INIT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        regWriteM,
  input  logic        regWriteW,
  input  logic [1:0]  resultSrcE,
  input  logic        PCSrcE,
  input  logic        memReqM,
  input  logic        memReadyM,
  output logic [1:0]  forwardAE,
  output logic [1:0]  forwardBE,
  output logic        stallF,
  output logic        stallD,
  output logic        stallE,
  output logic        stallM,
  output logic        flushD,
  output logic        flushE,
  output logic        flushW,
  output logic        memErr,
  output logic [31:0] stallCnt,
  output logic [31:0] flushCnt
);

  // The INIT counter only needs to reach INIT_CYCLES-1; at least one bit wide.
  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [INIT_W-1:0] INIT_LAST =
    INIT_W'((INIT_CYCLES > 1) ? INIT_CYCLES - 1 : 0);

  // The wait counter holds the number of completed MEMWAIT cycles, so the
  // timeout is flagged during the cycle in which the count would reach
  // MEM_TIMEOUT. The threshold is clamped to what a 4-bit counter can hit.
  localparam logic [3:0] ERR_CNT =
    4'((MEM_TIMEOUT < 1) ? 0 : ((MEM_TIMEOUT > 15) ? 14 : MEM_TIMEOUT - 1));

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    RUN     = 2'd1,
    MEMWAIT = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [INIT_W-1:0] init_cnt;
  logic [3:0]        wait_cnt;
  logic              err_q;
  logic              lw_stall;
  logic              mem_wait;
  logic              timeout_hit;

  // A load in Execute whose result is needed in Decode; a taken branch
  // squashes the dependent instruction, so no stall is needed then.
  assign lw_stall = (resultSrcE == 2'b01) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D)) && !PCSrcE;

  assign mem_wait = memReqM && !memReadyM;

  assign timeout_hit = (state == MEMWAIT) && (wait_cnt == ERR_CNT);
  assign memErr      = err_q || timeout_hit;

  // Operand A select: the younger Memory-stage result wins over Writeback.
  always_comb begin
    forwardAE = 2'b00;
    if (regWriteM && (RdM != 5'd0) && (RdM == Rs1E)) begin
      forwardAE = 2'b10;
    end else if (regWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
      forwardAE = 2'b01;
    end
  end

  // Operand B select, same priority as operand A.
  always_comb begin
    forwardBE = 2'b00;
    if (regWriteM && (RdM != 5'd0) && (RdM == Rs2E)) begin
      forwardBE = 2'b10;
    end else if (regWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
      forwardBE = 2'b01;
    end
  end

  // Next-state and stall/flush mapping, selected by the FSM state.
  always_comb begin
    state_next = state;
    stallF     = 1'b0;
    stallD     = 1'b0;
    stallE     = 1'b0;
    stallM     = 1'b0;
    flushD     = 1'b0;
    flushE     = 1'b0;
    flushW     = 1'b0;
    if (rst) begin
      state_next = INIT;
      stallF     = 1'b1;
      flushD     = 1'b1;
      flushE     = 1'b1;
      flushW     = 1'b1;
    end else begin
      case (state)
        INIT: begin
          stallF = 1'b1;
          flushD = 1'b1;
          flushE = 1'b1;
          flushW = 1'b1;
          if (init_cnt == INIT_LAST) begin
            state_next = RUN;
          end
        end
        RUN: begin
          if (mem_wait) begin
            stallF     = 1'b1;
            stallD     = 1'b1;
            stallE     = 1'b1;
            stallM     = 1'b1;
            flushW     = 1'b1;
            state_next = MEMWAIT;
          end else begin
            stallF = lw_stall;
            stallD = lw_stall;
            flushD = PCSrcE;
            flushE = lw_stall || PCSrcE;
          end
        end
        MEMWAIT: begin
          if (memReadyM) begin
            stallF     = lw_stall;
            stallD     = lw_stall;
            flushD     = PCSrcE;
            flushE     = lw_stall || PCSrcE;
            state_next = RUN;
          end else begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
          end
        end
        default: begin
          stallF     = 1'b1;
          flushD     = 1'b1;
          flushE     = 1'b1;
          flushW     = 1'b1;
          state_next = INIT;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  // INIT flush counter, saturating MEMWAIT counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt <= '0;
      wait_cnt <= 4'd0;
      err_q    <= 1'b0;
    end else begin
      if ((state == INIT) && (init_cnt != INIT_LAST)) begin
        init_cnt <= init_cnt + 1'b1;
      end
      if ((state != MEMWAIT) && (state_next == MEMWAIT)) begin
        wait_cnt <= 4'd0;
      end else if ((state == MEMWAIT) && (wait_cnt != 4'd15)) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Performance counters: stalled fetch cycles and flushing RUN cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (((state == RUN) || (state == MEMWAIT)) && stallF) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if ((state == RUN) && (flushD || flushE)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stallCnt = stall_cnt_q;
  assign flushCnt = flush_cnt_q;
`else
  assign stallCnt = 32'd0;
  assign flushCnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- self-checking bench for hazard_ctrl.
// A behavioural model tracks the flush window, the memory wait and the
// counters; a compare process checks every output on each falling edge.
// Directed scenarios add literal expectations, then random stimulus runs.
module tb_hazard_ctrl;

  localparam int INIT_CYCLES = 2;
  localparam int MEM_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        regWriteM, regWriteW;
  logic [1:0]  resultSrcE;
  logic        PCSrcE, memReqM, memReadyM;
  logic [1:0]  forwardAE, forwardBE;
  logic        stallF, stallD, stallE, stallM;
  logic        flushD, flushE, flushW;
  logic        memErr;
  logic [31:0] stallCnt, flushCnt;

  typedef struct packed {
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       regWriteM, regWriteW;
    logic [1:0] resultSrcE;
    logic       PCSrcE, memReqM, memReadyM;
  } stim_t;

  typedef struct packed {
    logic stallF, stallD, stallE, stallM, flushD, flushE, flushW;
  } ctrl_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  bit          m_valid  = 1'b0;
  int          m_init_left;
  bit          m_waiting;
  int          m_wait_cycles;
  bit          m_err;
  int unsigned m_scnt;
  int unsigned m_fcnt;
  ctrl_t       mc;
  ctrl_t       ec;
  stim_t       s;
  int          mem_left = -1;

  hazard_ctrl #(
    .INIT_CYCLES(INIT_CYCLES),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .regWriteM(regWriteM), .regWriteW(regWriteW),
    .resultSrcE(resultSrcE), .PCSrcE(PCSrcE),
    .memReqM(memReqM), .memReadyM(memReadyM),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .memErr(memErr), .stallCnt(stallCnt), .flushCnt(flushCnt)
  );

  always #5 clk = ~clk;

  // One comparison; counts passes and reports any difference.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  task automatic driveInputs(input stim_t v);
    rst        = v.rst;
    Rs1D       = v.Rs1D;
    Rs2D       = v.Rs2D;
    Rs1E       = v.Rs1E;
    Rs2E       = v.Rs2E;
    RdE        = v.RdE;
    RdM        = v.RdM;
    RdW        = v.RdW;
    regWriteM  = v.regWriteM;
    regWriteW  = v.regWriteW;
    resultSrcE = v.resultSrcE;
    PCSrcE     = v.PCSrcE;
    memReqM    = v.memReqM;
    memReadyM  = v.memReadyM;
  endtask

  // Inputs change shortly after the rising edge and hold for one cycle.
  task automatic applyStimulus(input stim_t v);
    @(posedge clk);
    #1;
    driveInputs(v);
  endtask

  // Forwarding select for one source register.
  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (regWriteM && RdM != 5'd0 && RdM == rs) return 2'b10;
    if (regWriteW && RdW != 5'd0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Stall/flush outputs from the model's view of the pipeline condition.
  function automatic ctrl_t exp_ctrl();
    ctrl_t c;
    logic  lw;
    c  = '0;
    lw = (resultSrcE == 2'b01) && (RdE != 5'd0) &&
         ((RdE == Rs1D) || (RdE == Rs2D)) && !PCSrcE;
    if (rst || m_init_left > 0) begin
      c.stallF = 1'b1; c.flushD = 1'b1; c.flushE = 1'b1; c.flushW = 1'b1;
    end else if (!memReadyM && (m_waiting || memReqM)) begin
      c.stallF = 1'b1; c.stallD = 1'b1; c.stallE = 1'b1; c.stallM = 1'b1;
      c.flushW = 1'b1;
    end else begin
      c.stallF = lw;
      c.stallD = lw;
      c.flushD = PCSrcE;
      c.flushE = lw || PCSrcE;
    end
    return c;
  endfunction

  // Model update: flush window countdown, memory wait tracking, counters.
  always @(posedge clk) begin
    mc = exp_ctrl();
    if (rst) begin
      m_valid       <= 1'b1;
      m_init_left   <= INIT_CYCLES;
      m_waiting     <= 1'b0;
      m_wait_cycles <= 0;
      m_err         <= 1'b0;
      m_scnt        <= 0;
      m_fcnt        <= 0;
    end else if (m_init_left > 0) begin
      m_init_left <= m_init_left - 1;
    end else begin
      if (mc.stallF) m_scnt <= m_scnt + 1;
      if (!m_waiting && (mc.flushD || mc.flushE)) m_fcnt <= m_fcnt + 1;
      if (m_waiting) begin
        if (m_wait_cycles >= MEM_TIMEOUT) m_err <= 1'b1;
        if (memReadyM) m_waiting <= 1'b0;
        else m_wait_cycles <= m_wait_cycles + 1;
      end else if (memReqM && !memReadyM) begin
        m_waiting     <= 1'b1;
        m_wait_cycles <= 1;
      end
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      ec = exp_ctrl();
      checkOutput("fwdA", 32'(forwardAE), 32'(exp_fwd(Rs1E)));
      checkOutput("fwdB", 32'(forwardBE), 32'(exp_fwd(Rs2E)));
      checkOutput("stallF", 32'(stallF), 32'(ec.stallF));
      checkOutput("stallD", 32'(stallD), 32'(ec.stallD));
      checkOutput("stallE", 32'(stallE), 32'(ec.stallE));
      checkOutput("stallM", 32'(stallM), 32'(ec.stallM));
      checkOutput("flushD", 32'(flushD), 32'(ec.flushD));
      checkOutput("flushE", 32'(flushE), 32'(ec.flushE));
      checkOutput("flushW", 32'(flushW), 32'(ec.flushW));
      checkOutput("memErr", 32'(memErr),
                  32'(m_err || (m_waiting && m_wait_cycles >= MEM_TIMEOUT)));
`ifdef HAZARD_PERF_EN
      checkOutput("stallCnt", stallCnt, m_scnt);
      checkOutput("flushCnt", flushCnt, m_fcnt);
`else
      checkOutput("stallCnt", stallCnt, 32'd0);
      checkOutput("flushCnt", flushCnt, 32'd0);
`endif
    end
  end

  // Directed scenarios with literal expectations, then random stimulus.
  initial begin
    s     = '0;
    s.rst = 1'b1;
    driveInputs(s);
    $display("[TB] reset and flush window");
    @(negedge clk);
    checkOutput("rst_stallF", 32'(stallF), 32'd1);
    checkOutput("rst_flushW", 32'(flushW), 32'd1);
    s.rst = 1'b0;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("init1_flushD", 32'(flushD), 32'd1);
    checkOutput("init1_stallD", 32'(stallD), 32'd0);
    applyStimulus(s);
    @(negedge clk);
    checkOutput("init2_stallF", 32'(stallF), 32'd1);
    checkOutput("init2_flushE", 32'(flushE), 32'd1);
    applyStimulus(s);
    @(negedge clk);
    checkOutput("run_stallF", 32'(stallF), 32'd0);
    checkOutput("run_flushW", 32'(flushW), 32'd0);
    checkOutput("run_flushD", 32'(flushD), 32'd0);

    $display("[TB] load-use stalls and taken branches");
    for (int i = 0; i < 3; i++) begin
      s = '0; s.resultSrcE = 2'b01; s.RdE = 5'd7; s.Rs2D = 5'd7;
      applyStimulus(s);
      @(negedge clk);
      checkOutput("lu_stallF", 32'(stallF), 32'd1);
      checkOutput("lu_stallD", 32'(stallD), 32'd1);
      checkOutput("lu_flushE", 32'(flushE), 32'd1);
      checkOutput("lu_flushD", 32'(flushD), 32'd0);
      s = '0;
      applyStimulus(s);
    end
    for (int i = 0; i < 2; i++) begin
      s = '0; s.PCSrcE = 1'b1;
      applyStimulus(s);
      s = '0;
      applyStimulus(s);
    end
    @(negedge clk);
`ifdef HAZARD_PERF_EN
    checkOutput("perf_stallCnt", stallCnt, 32'd3);
    checkOutput("perf_flushCnt", flushCnt, 32'd5);
`else
    checkOutput("perf_stallCnt", stallCnt, 32'd0);
    checkOutput("perf_flushCnt", flushCnt, 32'd0);
`endif
    s = '0; s.resultSrcE = 2'b01; s.RdE = 5'd7; s.Rs2D = 5'd7; s.PCSrcE = 1'b1;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("lub_stallF", 32'(stallF), 32'd0);
    checkOutput("lub_flushD", 32'(flushD), 32'd1);
    checkOutput("lub_flushE", 32'(flushE), 32'd1);

    $display("[TB] forwarding");
    s = '0; s.RdM = 5'd5; s.RdW = 5'd5; s.Rs1E = 5'd5;
    s.regWriteM = 1'b1; s.regWriteW = 1'b1;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("fwd_mem", 32'(forwardAE), 32'd2);
    s.regWriteM = 1'b0;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("fwd_wb", 32'(forwardAE), 32'd1);
    s.regWriteM = 1'b1; s.RdM = 5'd0; s.RdW = 5'd0;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("fwd_x0", 32'(forwardAE), 32'd0);
    s = '0; s.RdM = 5'd9; s.RdW = 5'd9; s.Rs2E = 5'd9; s.Rs1E = 5'd3;
    s.regWriteM = 1'b1; s.regWriteW = 1'b1;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("fwdB_mem", 32'(forwardBE), 32'd2);
    checkOutput("fwdA_none", 32'(forwardAE), 32'd0);

    $display("[TB] memory wait");
    s = '0; s.memReqM = 1'b1; s.PCSrcE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(s);
      @(negedge clk);
      checkOutput("mw_stallE", 32'(stallE), 32'd1);
      checkOutput("mw_stallM", 32'(stallM), 32'd1);
      checkOutput("mw_flushW", 32'(flushW), 32'd1);
      checkOutput("mw_flushD", 32'(flushD), 32'd0);
    end
    s.memReadyM = 1'b1;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("rel_stallF", 32'(stallF), 32'd0);
    checkOutput("rel_flushD", 32'(flushD), 32'd1);
    checkOutput("rel_flushW", 32'(flushW), 32'd0);
    checkOutput("rel_memErr", 32'(memErr), 32'd0);
    s = '0;
    applyStimulus(s);

    $display("[TB] memory timeout");
    s = '0; s.memReqM = 1'b1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(s);
      @(negedge clk);
      if (i == 14) checkOutput("to_before", 32'(memErr), 32'd0);
      if (i == 15) checkOutput("to_hit", 32'(memErr), 32'd1);
    end
    s.memReadyM = 1'b1;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("to_release", 32'(memErr), 32'd1);
    s = '0;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("to_sticky", 32'(memErr), 32'd1);
    s.rst = 1'b1;
    applyStimulus(s);
    s.rst = 1'b0;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("to_cleared", 32'(memErr), 32'd0);
    applyStimulus(s);

    $display("[TB] reset during memory wait");
    applyStimulus(s);
    s = '0; s.memReqM = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(s);
    s.rst = 1'b1;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("rmw_stallE", 32'(stallE), 32'd0);
    checkOutput("rmw_flushW", 32'(flushW), 32'd1);
    s = '0;
    for (int i = 0; i < 3; i++) applyStimulus(s);
    @(negedge clk);
    checkOutput("rmw_run_stallF", 32'(stallF), 32'd0);
    checkOutput("rmw_run_stallM", 32'(stallM), 32'd0);

    $display("[TB] random stimulus");
    for (int i = 0; i < 3000; i++) begin
      s.rst        = ($urandom_range(0, 199) == 0);
      s.Rs1D       = 5'($urandom_range(0, 3));
      s.Rs2D       = 5'($urandom_range(0, 3));
      s.Rs1E       = 5'($urandom_range(0, 3));
      s.Rs2E       = 5'($urandom_range(0, 3));
      s.RdE        = 5'($urandom_range(0, 3));
      s.RdM        = 5'($urandom_range(0, 3));
      s.RdW        = 5'($urandom_range(0, 3));
      s.regWriteM  = 1'($urandom_range(0, 1));
      s.regWriteW  = 1'($urandom_range(0, 1));
      s.resultSrcE = 2'($urandom_range(0, 3));
      s.PCSrcE     = ($urandom_range(0, 3) == 0);
      if (mem_left < 0 && $urandom_range(0, 5) == 0) begin
        mem_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 20))
                                               : int'($urandom_range(0, 4));
      end
      if (mem_left >= 0) begin
        s.memReqM   = 1'b1;
        s.memReadyM = (mem_left == 0);
        mem_left--;
      end else begin
        s.memReqM   = 1'b0;
        s.memReadyM = 1'($urandom_range(0, 1));
      end
      applyStimulus(s);
    end
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
